// File: rtl/ql_reserved_wdt_regs.sv
// Reserved-aperture ID/scratch registers plus a programmable bus watchdog
// that default-acks and logs unanswered fabric accesses.
module ql_reserved_wdt_regs #(
  parameter int ADDRWIDTH = 7,
  parameter int DATAWIDTH = 32,
  parameter int CNTR_WIDTH = 3,
  parameter int TIMEOUT_DEFAULT = 7,
  parameter logic [ADDRWIDTH-1:0] ADR_TO_ADDR = 7'h7A,
  parameter logic [ADDRWIDTH-1:0] ADR_TO_STATUS = 7'h7B,
  parameter logic [ADDRWIDTH-1:0] ADR_TO_CFG = 7'h7C,
  parameter logic [ADDRWIDTH-1:0] ADR_SCRATCH = 7'h7D,
  parameter logic [ADDRWIDTH-1:0] ADR_CUST_PROD = 7'h7E,
  parameter logic [ADDRWIDTH-1:0] ADR_REVISIONS = 7'h7F,
  parameter logic [7:0] CUSTOMER_ID = 8'h01,
  parameter logic [7:0] PRODUCT_ID = 8'h00,
  parameter logic [15:0] MAJOR_REV = 16'h0002,
  parameter logic [15:0] MINOR_REV = 16'h0000,
  parameter logic [DATAWIDTH-1:0] DEF_REG_VALUE = 32'hDEF_FAB_AC
) (
  input  logic                 WBs_CLK_i,
  input  logic                 WBs_RST_n_i,
  input  logic [ADDRWIDTH-1:0] WBs_ADR_i,
  input  logic                 WBs_CYC_QL_Reserved_i,
  input  logic                 WBs_CYC_i,
  input  logic                 WBs_STB_i,
  input  logic                 WBs_WE_i,
  input  logic [3:0]           WBs_BYTE_STB_i,
  input  logic [DATAWIDTH-1:0] WBs_DAT_i,
  input  logic                 WBs_ACK_i,
  output logic [DATAWIDTH-1:0] WBs_DAT_o,
  output logic                 WBs_ACK_o,
  output logic                 Timeout_Irq_o
);

  typedef enum logic [1:0] {IDLE, COUNT, TACK} state_t;

  localparam logic [CNTR_WIDTH-1:0] TDEF = CNTR_WIDTH'(TIMEOUT_DEFAULT);
  localparam logic [31:0] CFG_MASK =
    {1'b1, {(31-CNTR_WIDTH){1'b0}}, {CNTR_WIDTH{1'b1}}};
  localparam logic [31:0] CFG_RST =
    {1'b0, {(31-CNTR_WIDTH){1'b0}}, TDEF};

  state_t state_q, state_d;
  logic [CNTR_WIDTH-1:0] cntr_q, cntr_d;
  logic [CNTR_WIDTH-1:0] tval;
  logic [31:0] scratch_q, cfg_q, rdata;
  logic flag_q;
  logic [7:0] tcnt_q, tbase;
  logic [ADDRWIDTH-1:0] tadr_q;
  logic res_ack, tack, wr, w1c;

  function automatic logic [31:0] lanes(
    input logic [31:0] o,
    input logic [31:0] n,
    input logic [3:0]  be
  );
    lanes = o;
    for (int i = 0; i < 4; i++)
      if (be[i]) lanes[8*i +: 8] = n[8*i +: 8];
  endfunction

  assign tval = cfg_q[CNTR_WIDTH-1:0];
  assign res_ack = WBs_CYC_QL_Reserved_i & WBs_STB_i & ~WBs_ACK_o;
  assign tack = (state_q == TACK);
  assign wr = res_ack & WBs_WE_i;
  assign w1c = wr & (WBs_ADR_i == ADR_TO_STATUS)
             & WBs_BYTE_STB_i[0] & WBs_DAT_i[0];
  // a clear landing with a timeout log is applied first, then the log
  assign tbase = w1c ? 8'h00 : tcnt_q;

  always_comb begin
    state_d = state_q;
    cntr_d = cntr_q;
    unique case (state_q)
      IDLE: begin
        if (WBs_CYC_i & WBs_STB_i & ~WBs_CYC_QL_Reserved_i
            & (tval != '0)) begin
          state_d = COUNT;
          cntr_d = tval;
        end
      end
      COUNT: begin
        if (WBs_ACK_i)
          state_d = IDLE;
        else if (!(WBs_CYC_i & WBs_STB_i))
          state_d = IDLE;
        else if (cntr_q == CNTR_WIDTH'(1))
          state_d = TACK;
        else
          cntr_d = cntr_q - CNTR_WIDTH'(1);
      end
      TACK: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rdata = DEF_REG_VALUE;
    case (WBs_ADR_i)
      ADR_TO_ADDR:
        rdata = {{(DATAWIDTH-ADDRWIDTH){1'b0}}, tadr_q};
      ADR_TO_STATUS: rdata = {16'h0, tcnt_q, 7'h0, flag_q};
      ADR_TO_CFG: rdata = cfg_q;
      ADR_SCRATCH: rdata = scratch_q;
      ADR_CUST_PROD: rdata = {16'h0, CUSTOMER_ID, PRODUCT_ID};
      ADR_REVISIONS: rdata = {MAJOR_REV, MINOR_REV};
      default: rdata = DEF_REG_VALUE;
    endcase
  end

  always_ff @(posedge WBs_CLK_i) begin
    if (!WBs_RST_n_i) begin
      state_q <= IDLE;
      cntr_q <= '0;
      WBs_ACK_o <= 1'b0;
      WBs_DAT_o <= '0;
      Timeout_Irq_o <= 1'b0;
      scratch_q <= '0;
      cfg_q <= CFG_RST;
      flag_q <= 1'b0;
      tcnt_q <= '0;
      tadr_q <= '0;
    end else begin
      state_q <= state_d;
      cntr_q <= cntr_d;
      WBs_ACK_o <= res_ack | tack;
      if (tack)
        WBs_DAT_o <= DEF_REG_VALUE;
      else if (res_ack)
        WBs_DAT_o <= rdata;
      Timeout_Irq_o <= flag_q & cfg_q[31];
      if (wr && WBs_ADR_i == ADR_SCRATCH)
        scratch_q <= lanes(scratch_q, WBs_DAT_i, WBs_BYTE_STB_i);
      if (wr && WBs_ADR_i == ADR_TO_CFG)
        cfg_q <= lanes(cfg_q, WBs_DAT_i, WBs_BYTE_STB_i) & CFG_MASK;
      if (tack) begin
        flag_q <= 1'b1;
        tcnt_q <= (tbase == 8'hFF) ? tbase : tbase + 8'd1;
        tadr_q <= WBs_ADR_i;
      end else if (w1c) begin
        flag_q <= 1'b0;
        tcnt_q <= 8'h00;
      end
    end
  end

endmodule

// File: tb/tb_ql_reserved_wdt_regs.sv
// Randomized bench for ql_reserved_wdt_regs against a register-map
// and timeout-log reference model.
module tb_ql_reserved_wdt_regs;

  localparam logic [31:0] DEF = 32'hDEFFABAC;

  logic clk = 0;
  logic rst_n;
  logic [6:0] adr;
  logic cyc_ql, cyc, stb, we, ack_i;
  logic [3:0] be;
  logic [31:0] dat_i, dat_o;
  logic ack_o, irq;

  int total = 0;
  int bad = 0;

  logic [31:0] m_scratch, m_cfg;
  logic m_flag;
  int m_cnt;
  logic [6:0] m_addr;

  always #5 clk = ~clk;

  ql_reserved_wdt_regs dut (
    .WBs_CLK_i(clk),
    .WBs_RST_n_i(rst_n),
    .WBs_ADR_i(adr),
    .WBs_CYC_QL_Reserved_i(cyc_ql),
    .WBs_CYC_i(cyc),
    .WBs_STB_i(stb),
    .WBs_WE_i(we),
    .WBs_BYTE_STB_i(be),
    .WBs_DAT_i(dat_i),
    .WBs_ACK_i(ack_i),
    .WBs_DAT_o(dat_o),
    .WBs_ACK_o(ack_o),
    .Timeout_Irq_o(irq)
  );

  function automatic logic [31:0] merge(
    input logic [31:0] o, input logic [31:0] n, input logic [3:0] b);
    logic [31:0] m;
    m = {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
    return (o & ~m) | (n & m);
  endfunction

  task automatic m_reset();
    m_scratch = 0; m_cfg = 32'd7; m_flag = 0; m_cnt = 0; m_addr = 0;
  endtask

  task automatic m_write(input logic [6:0] a, input logic [31:0] d,
                         input logic [3:0] b);
    if (a == 7'h7D) m_scratch = merge(m_scratch, d, b);
    if (a == 7'h7C) m_cfg = merge(m_cfg, d, b) & 32'h8000_0007;
    if (a == 7'h7B && b[0] && d[0]) begin m_flag = 0; m_cnt = 0; end
  endtask

  task automatic m_timeout(input logic [6:0] a);
    m_flag = 1;
    m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
    m_addr = a;
  endtask

  function automatic logic [31:0] m_read(input logic [6:0] a);
    case (a)
      7'h7A: return {25'h0, m_addr};
      7'h7B: return {16'h0, 8'(m_cnt), 7'h0, m_flag};
      7'h7C: return m_cfg;
      7'h7D: return m_scratch;
      7'h7E: return 32'h0000_0100;
      7'h7F: return 32'h0002_0000;
      default: return DEF;
    endcase
  endfunction

  task automatic idle_bus();
    cyc = 0; stb = 0; cyc_ql = 0; we = 0; ack_i = 0;
  endtask

  // lat: edge index whose registered ACK_o was seen, -1 if none
  task automatic bus(input logic [6:0] a, input bit res, input bit w,
                     input logic [31:0] d, input logic [3:0] b,
                     input int ack_at, input int drop_at, input int maxc,
                     output int lat, output logic [31:0] rd,
                     output bit w1);
    bit act;
    lat = -1; rd = '0; w1 = 0; act = 1;
    @(negedge clk);
    adr = a; cyc_ql = res; cyc = 1; stb = 1; we = w;
    dat_i = d; be = b;
    ack_i = (ack_at == 0);
    for (int e = 0; e < maxc; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (ack_i) begin act = 0; idle_bus(); end
      if (ack_o) begin lat = e; rd = dat_o; break; end
      if (act && drop_at == e + 1) begin
        if ($urandom_range(0, 1) != 0) stb = 0; else cyc = 0;
        act = 0;
      end
      if (act && ack_at == e + 1) ack_i = 1;
    end
    idle_bus();
    if (lat >= 0) begin
      @(posedge clk);
      @(negedge clk);
      w1 = !ack_o;
    end
  endtask

  task automatic rd_reg(input logic [6:0] a, output logic [31:0] v);
    int l; bit w1;
    bus(a, 1, 0, 0, 0, -1, -1, 4, l, v, w1);
  endtask

  task automatic wr_reg(input logic [6:0] a, input logic [31:0] d,
                        input logic [3:0] b);
    int l; logic [31:0] v; bit w1;
    bus(a, 1, 1, d, b, -1, -1, 4, l, v, w1);
    m_write(a, d, b);
  endtask

  task automatic test_reset();
    logic [31:0] v;
    logic [6:0] regs [4] = '{7'h7A, 7'h7B, 7'h7C, 7'h7D};
    idle_bus(); adr = 0; be = 0; dat_i = 0; rst_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (ack_o !== 0 || dat_o !== 0 || irq !== 0) begin
      bad++;
      $display("FAIL reset_out got ack=%b dat=%h irq=%b exp 0/0/0",
               ack_o, dat_o, irq);
    end
    rst_n = 1;
    m_reset();
    foreach (regs[i]) begin
      rd_reg(regs[i], v);
      total++;
      if (v !== m_read(regs[i])) begin
        bad++;
        $display("FAIL reset_reg %h got=%h exp=%h", regs[i], v,
                 m_read(regs[i]));
      end
    end
  endtask

  task automatic test_id_regs();
    logic [6:0] a; int l; logic [31:0] v; bit w1;
    for (int i = 0; i < 6; i++) begin
      case (i)
        0: a = 7'h7E;
        1: a = 7'h7F;
        2: a = 7'h55;
        default: a = 7'($urandom_range(0, 'h79));
      endcase
      bus(a, 1, 0, 0, 0, -1, -1, 4, l, v, w1);
      total++;
      if (l !== 0 || w1 !== 1 || v !== m_read(a)) begin
        bad++;
        $display("FAIL id_read %h got lat=%0d w1=%b dat=%h exp 0/1/%h",
                 a, l, w1, v, m_read(a));
      end
    end
  endtask

  task automatic test_scratch();
    logic [31:0] v, d; logic [3:0] b;
    for (int i = 0; i < 5; i++) begin
      d = (i == 0) ? 32'hA5A5_1234 : $urandom;
      b = (i == 0) ? 4'b0101 : 4'($urandom);
      wr_reg(7'h7D, d, b);
      rd_reg(7'h7D, v);
      total++;
      if (v !== m_read(7'h7D)) begin
        bad++;
        $display("FAIL scratch d=%h be=%b got=%h exp=%h", d, b, v,
                 m_read(7'h7D));
      end
    end
    wr_reg(7'h7E, $urandom, 4'hF);
    rd_reg(7'h7E, v);
    total++;
    if (v !== m_read(7'h7E)) begin
      bad++;
      $display("FAIL ro_write got=%h exp=%h", v, m_read(7'h7E));
    end
  endtask

  task automatic test_timeout();
    logic [6:0] a; int l, t; logic [31:0] v, s, ta; bit w1;
    for (int i = 0; i < 4; i++) begin
      t = (i == 0) ? 7 : $urandom_range(1, 7);
      a = (i == 0) ? 7'h13 : 7'($urandom);
      wr_reg(7'h7C, {(i == 0) | ($urandom_range(0, 1) != 0), 28'h0,
                     3'(t)}, 4'hF);
      bus(a, 0, $urandom_range(0, 1) != 0, $urandom, 4'hF,
          -1, -1, 20, l, v, w1);
      m_timeout(a);
      total++;
      if (l !== t + 1 || v !== DEF || w1 !== 1) begin
        bad++;
        $display("FAIL timeout_ack T=%0d got lat=%0d dat=%h w1=%b exp %0d/%h/1",
                 t, l, v, w1, t + 1, DEF);
      end
      rd_reg(7'h7B, s);
      rd_reg(7'h7A, ta);
      total++;
      if (s !== m_read(7'h7B) || ta !== m_read(7'h7A)) begin
        bad++;
        $display("FAIL timeout_log got st=%h ad=%h exp st=%h ad=%h",
                 s, ta, m_read(7'h7B), m_read(7'h7A));
      end
      total++;
      if (irq !== (m_flag & m_cfg[31])) begin
        bad++;
        $display("FAIL irq got=%b exp=%b", irq, m_flag & m_cfg[31]);
      end
    end
  endtask

  task automatic test_ip_ack();
    int l, t, at; logic [31:0] v, s; bit w1;
    for (int i = 0; i < 4; i++) begin
      t = (i < 2) ? 7 : $urandom_range(1, 7);
      at = (i == 0) ? 4 : (i == 1) ? t : $urandom_range(1, t);
      wr_reg(7'h7C, 32'(t), 4'hF);
      bus(7'($urandom_range(0, 'h79)), 0, 0, 0, 4'hF,
          at, -1, 12, l, v, w1);
      total++;
      if (l !== -1) begin
        bad++;
        $display("FAIL ip_ack T=%0d at=%0d got lat=%0d exp none",
                 t, at, l);
      end
      rd_reg(7'h7B, s);
      total++;
      if (s !== m_read(7'h7B)) begin
        bad++;
        $display("FAIL ip_ack_status got=%h exp=%h", s, m_read(7'h7B));
      end
    end
  endtask

  task automatic test_disable_abort();
    int l; logic [31:0] v, s; bit w1; logic [6:0] a;
    wr_reg(7'h7C, 32'h0, 4'hF);
    bus(7'h21, 0, 0, 0, 4'hF, -1, -1, 20, l, v, w1);
    total++;
    if (l !== -1) begin
      bad++;
      $display("FAIL disabled got lat=%0d exp none", l);
    end
    wr_reg(7'h7C, 32'h3, 4'hF);
    a = 7'($urandom);
    bus(a, 0, 0, 0, 4'hF, -1, -1, 20, l, v, w1);
    m_timeout(a);
    total++;
    if (l !== 4) begin
      bad++;
      $display("FAIL t3_latency got=%0d exp=4", l);
    end
    bus(7'h22, 0, 0, 0, 4'hF, -1, 2, 12, l, v, w1);
    rd_reg(7'h7B, s);
    total++;
    if (l !== -1 || s !== m_read(7'h7B)) begin
      bad++;
      $display("FAIL abort got lat=%0d st=%h exp none/%h", l, s,
               m_read(7'h7B));
    end
  endtask

  task automatic test_saturate_w1c();
    int l; logic [31:0] v, s; bit w1; logic [6:0] a;
    wr_reg(7'h7C, 32'h1, 4'hF);
    for (int i = 0; i < 256; i++) begin
      a = 7'($urandom);
      bus(a, 0, 0, 0, 4'hF, -1, -1, 8, l, v, w1);
      m_timeout(a);
      total++;
      if (l !== 2) begin
        bad++;
        $display("FAIL sat_lat i=%0d got=%0d exp=2", i, l);
      end
    end
    rd_reg(7'h7B, s);
    total++;
    if (s !== m_read(7'h7B)) begin
      bad++;
      $display("FAIL saturate got=%h exp=%h", s, m_read(7'h7B));
    end
    wr_reg(7'h7B, 32'h1, 4'h1);
    rd_reg(7'h7B, s);
    total++;
    if (s !== m_read(7'h7B)) begin
      bad++;
      $display("FAIL w1c got=%h exp=%h", s, m_read(7'h7B));
    end
    for (int i = 0; i < 2; i++) begin
      bus(7'h30, 0, 0, 0, 4'hF, -1, -1, 8, l, v, w1);
      m_timeout(7'h30);
    end
    // clear write arrives on the same edge the watchdog logs
    @(negedge clk);
    adr = 7'h20; cyc_ql = 0; cyc = 1; stb = 1; we = 0;
    repeat (2) begin @(posedge clk); @(negedge clk); end
    adr = 7'h7B; cyc_ql = 1; we = 1; dat_i = 32'h1; be = 4'h1;
    @(posedge clk);
    @(negedge clk);
    total++;
    if (ack_o !== 1 || dat_o !== DEF) begin
      bad++;
      $display("FAIL coinc_ack got ack=%b dat=%h exp 1/%h", ack_o, dat_o,
               DEF);
    end
    idle_bus();
    m_write(7'h7B, 32'h1, 4'h1);
    m_timeout(7'h7B);
    rd_reg(7'h7B, s);
    rd_reg(7'h7A, v);
    total++;
    if (s !== m_read(7'h7B) || v !== m_read(7'h7A)) begin
      bad++;
      $display("FAIL coinc_log got st=%h ad=%h exp %h/%h", s, v,
               m_read(7'h7B), m_read(7'h7A));
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] v; bit seen;
    logic [6:0] regs [4] = '{7'h7A, 7'h7B, 7'h7C, 7'h7D};
    wr_reg(7'h7C, 32'h8000_0007, 4'hF);
    wr_reg(7'h7D, $urandom | 32'h1, 4'hF);
    @(negedge clk);
    adr = 7'h44; cyc = 1; stb = 1; cyc_ql = 0;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    rst_n = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    idle_bus();
    m_reset();
    total++;
    if (ack_o !== 0 || dat_o !== 0 || irq !== 0) begin
      bad++;
      $display("FAIL midrst_out got ack=%b dat=%h irq=%b exp 0/0/0",
               ack_o, dat_o, irq);
    end
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (ack_o) seen = 1;
    end
    total++;
    if (seen) begin
      bad++;
      $display("FAIL midrst_ack got ack seen exp none");
    end
    foreach (regs[i]) begin
      rd_reg(regs[i], v);
      total++;
      if (v !== m_read(regs[i])) begin
        bad++;
        $display("FAIL midrst_reg %h got=%h exp=%h", regs[i], v,
                 m_read(regs[i]));
      end
    end
  endtask

  initial begin
    test_reset();
    test_id_regs();
    test_scratch();
    test_timeout();
    test_ip_ack();
    test_disable_abort();
    test_saturate_w1c();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
